// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, control FSM state encoding
// and the select codes driven onto the datapath muxes.
package mips_pkg;

   localparam int STATE_BITS = 4;

   typedef enum logic [STATE_BITS-1:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_I_EXEC    = 4'd10,
      S_I_WB      = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALU_MODE_ADD  = 2'b00;
   localparam logic [1:0] ALU_MODE_SUB  = 2'b01;
   localparam logic [1:0] ALU_MODE_FUNC = 2'b10;

   localparam logic [1:0] SRC_B_REG     = 2'b00;
   localparam logic [1:0] SRC_B_FOUR    = 2'b01;
   localparam logic [1:0] SRC_B_IMM     = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   function automatic logic is_imm_alu(input logic [5:0] op);
      return op inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI};
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences PC, memory, IR, register file
// and ALU operand/mode selection through FETCH/DECODE/EXEC/MEM/WB states.
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [5:0]         i_op,
   input  logic               i_mem_ready,
   output logic               o_pc_write,
   output logic               o_pc_wr_cond,
   output logic [1:0]         o_pc_src,
   output logic               o_iord,
   output logic               o_mem_read,
   output logic               o_mem_write,
   output logic               o_ir_write,
   output logic               o_reg_dst,
   output logic               o_mem_to_reg,
   output logic               o_reg_write,
   output logic               o_alu_src_a,
   output logic [1:0]         o_alu_src_b,
   output logic [1:0]         o_alu_mode,
   output logic               o_illegal,
   output logic [STATE_W-1:0] o_state
);

   state_t state;
   state_t state_next;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Unused encodings 12-15 fall into the default arm and recover to FETCH.
   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:     state_next = i_mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (i_op == OP_LW || i_op == OP_SW) begin
               state_next = S_MEM_ADDR;
            end else if (i_op == OP_RTYPE) begin
               state_next = S_R_EXEC;
            end else if (i_op == OP_BEQ) begin
               state_next = S_BRANCH;
            end else if (i_op == OP_J) begin
               state_next = S_JUMP;
            end else if (is_imm_alu(i_op)) begin
               state_next = S_I_EXEC;
            end else begin
               state_next = S_FETCH;
            end
         end
         S_MEM_ADDR: begin
            if (i_op == OP_LW) begin
               state_next = S_MEM_READ;
            end else if (i_op == OP_SW) begin
               state_next = S_MEM_WRITE;
            end else begin
               state_next = S_FETCH;
            end
         end
         S_MEM_READ:  state_next = i_mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: state_next = i_mem_ready ? S_FETCH : S_MEM_WRITE;
         S_R_EXEC:    state_next = S_R_WB;
         S_I_EXEC:    state_next = S_I_WB;
         default:     state_next = S_FETCH;
      endcase
   end

   always_comb begin
      o_pc_write   = 1'b0;
      o_pc_wr_cond = 1'b0;
      o_pc_src     = PC_SRC_ALU;
      o_iord       = 1'b0;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_ir_write   = 1'b0;
      o_reg_dst    = 1'b0;
      o_mem_to_reg = 1'b0;
      o_reg_write  = 1'b0;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = SRC_B_REG;
      o_alu_mode   = ALU_MODE_ADD;
      o_illegal    = 1'b0;
      case (state)
         S_FETCH: begin
            o_mem_read  = 1'b1;
            o_alu_src_b = SRC_B_FOUR;
            o_ir_write  = i_mem_ready;
            o_pc_write  = i_mem_ready;
         end
         S_DECODE: begin
            o_alu_src_b = SRC_B_IMM_SH2;
            o_illegal   = !(i_op == OP_LW || i_op == OP_SW || i_op == OP_RTYPE ||
                            i_op == OP_BEQ || i_op == OP_J || is_imm_alu(i_op));
         end
         S_MEM_ADDR: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = SRC_B_IMM;
         end
         S_MEM_READ: begin
            o_mem_read = 1'b1;
            o_iord     = 1'b1;
         end
         S_MEM_WB: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            o_mem_write = 1'b1;
            o_iord      = 1'b1;
         end
         S_R_EXEC: begin
            o_alu_src_a = 1'b1;
            o_alu_mode  = ALU_MODE_FUNC;
         end
         S_R_WB: begin
            o_reg_write = 1'b1;
            o_reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            o_alu_src_a  = 1'b1;
            o_alu_mode   = ALU_MODE_SUB;
            o_pc_wr_cond = 1'b1;
            o_pc_src     = PC_SRC_ALUOUT;
         end
         S_JUMP: begin
            o_pc_write = 1'b1;
            o_pc_src   = PC_SRC_JUMP;
         end
         S_I_EXEC: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = SRC_B_IMM;
            o_alu_mode  = ALU_MODE_FUNC;
         end
         S_I_WB: begin
            o_reg_write = 1'b1;
         end
         default: begin
         end
      endcase
      // Reset abandons the instruction in flight, so no side effect may escape this cycle.
      if (i_rst) begin
         o_pc_write   = 1'b0;
         o_pc_wr_cond = 1'b0;
         o_ir_write   = 1'b0;
         o_reg_write  = 1'b0;
         o_mem_read   = 1'b0;
         o_mem_write  = 1'b0;
         o_illegal    = 1'b0;
      end
   end

   assign o_state = STATE_W'(state);

endmodule
